// File: rtl/mdc_transpose_unit_pkg.sv
// Shared types and helpers for the MDC transpose unit: complex sample layout,
// block mode encoding and a constant log2 used to size counters from LANES.
package mdc_transpose_unit_pkg;

  localparam int MTU_DW_DEFAULT = 64;
  localparam int MTU_HW_DEFAULT = MTU_DW_DEFAULT / 2;

  typedef enum logic {
    MODE_XPOSE  = 1'b0,
    MODE_BYPASS = 1'b1
  } mtu_mode_e;

  // Real half occupies the upper bits of a sample, imaginary half the lower bits.
  typedef struct packed {
    logic [MTU_HW_DEFAULT-1:0] re;
    logic [MTU_HW_DEFAULT-1:0] im;
  } cplx_t;

  function automatic logic [MTU_HW_DEFAULT-1:0] cplx_re(input cplx_t s);
    return s.re;
  endfunction

  function automatic logic [MTU_HW_DEFAULT-1:0] cplx_im(input cplx_t s);
    return s.im;
  endfunction

  function automatic int unsigned mdc_log2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int k = 0; k < 31; k++) begin
      if ((32'd1 << k) < n) r = k + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mdc_transpose_unit_stage.sv
// One 2x2 delay-commutator cell: the lower input is delayed DS beats before the
// switch and the upper switch output is delayed DS beats after it; SEL=1 crosses.
module mdc_stage #(
  parameter int DS = 1,
  parameter int DW = 64
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          EN,
  input  logic          SEL,
  input  logic [DW-1:0] A,
  input  logic [DW-1:0] B,
  output logic [DW-1:0] Y0,
  output logic [DW-1:0] Y1
);

  logic [DW-1:0] low_dl [DS];
  logic [DW-1:0] up_dl  [DS];
  logic [DW-1:0] low_q;
  logic [DW-1:0] sw_up;
  logic [DW-1:0] sw_low;

  assign low_q  = low_dl[DS-1];
  assign sw_up  = SEL ? low_q : A;
  assign sw_low = SEL ? A : low_q;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int k = 0; k < DS; k++) begin
        low_dl[k] <= '0;
        up_dl[k]  <= '0;
      end
    end else if (EN) begin
      low_dl[0] <= B;
      up_dl[0]  <= sw_up;
      for (int k = 1; k < DS; k++) begin
        low_dl[k] <= low_dl[k-1];
        up_dl[k]  <= up_dl[k-1];
      end
    end
  end

  assign Y0 = up_dl[DS-1];
  assign Y1 = sw_low;

endmodule

// File: rtl/mdc_transpose_unit.sv
// LANES x LANES block transpose (or per-block bypass) over log2(LANES) MDC stages,
// LANES-1 beat latency; stalls on IN_VALID=0. MTU_FLUSH_EN adds FLUSH drain beats.
module mdc_transpose_unit
  import mdc_transpose_unit_pkg::*;
#(
  parameter int LANES = 8,
  parameter int DW    = 64
) (
  input  logic                CLK,
  input  logic                RSTn,
  input  logic                IN_VALID,
  input  logic                BYPASS,
  input  logic [LANES*DW-1:0] D,
`ifdef MTU_FLUSH_EN
  input  logic                FLUSH,
`endif
  output logic                OUT_VALID,
  output logic                BLK_START,
  output logic [LANES*DW-1:0] Q
);

  localparam int S = mdc_log2(LANES);
  localparam logic [S-1:0] LAST = S'(LANES - 1);
  localparam int MW = (LANES > 2) ? LANES - 2 : 1;

  logic                en;
  logic [LANES*DW-1:0] din;
  logic [S-1:0]        cnt;
  logic [S-1:0]        fill;

`ifdef MTU_FLUSH_EN
  logic [S-1:0] drain;

  // Drain beats push zeros so the tail of the last block shifts out.
  assign en  = IN_VALID | (drain != '0);
  assign din = IN_VALID ? D : '0;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      drain <= '0;
    end else if (FLUSH) begin
      drain <= LAST;
    end else if (drain != '0) begin
      drain <= drain - 1'b1;
    end
  end
`else
  assign en  = IN_VALID;
  assign din = D;
`endif

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt  <= '0;
      fill <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
      if (fill != LAST) fill <= fill + 1'b1;
    end
  end

  // Mode of the block currently entering; mode_all[k] is that mode k beats ago.
  logic          mode_hold;
  logic          cur_mode;
  logic [MW-1:0] mode_sr;
  logic [MW:0]   mode_all;

  assign cur_mode = (cnt == '0) ? BYPASS : mode_hold;
  assign mode_all = {mode_sr, cur_mode};

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      mode_hold <= 1'b0;
      mode_sr   <= '0;
    end else if (en) begin
      mode_hold <= cur_mode;
      mode_sr   <= mode_all[MW-1:0];
    end
  end

  logic [DW-1:0] lane_d [S+1][LANES];

  for (genvar i = 0; i < LANES; i++) begin : g_io
    assign lane_d[0][i]   = din[i*DW +: DW];
    assign Q[i*DW +: DW]  = lane_d[S][i];
  end

  for (genvar s = 0; s < S; s++) begin : g_stage
    localparam int DSV = LANES >> (s + 1);
    localparam int TAP = LANES - 2 * DSV;
    logic sel;

    // Each stage sees its block window TAP beats after the input, so it taps mode there.
    assign sel = cnt[S-1-s] & (mode_all[TAP] != MODE_BYPASS);

    for (genvar i = 0; i < LANES; i++) begin : g_pair
      if ((i & DSV) == 0) begin : g_cell
        mdc_stage #(
          .DS(DSV),
          .DW(DW)
        ) u_cell (
          .CLK (CLK),
          .RSTn(RSTn),
          .EN  (en),
          .SEL (sel),
          .A   (lane_d[s][i]),
          .B   (lane_d[s][i+DSV]),
          .Y0  (lane_d[s+1][i]),
          .Y1  (lane_d[s+1][i+DSV])
        );
      end
    end
  end

  assign OUT_VALID = en && (fill == LAST);
  assign BLK_START = OUT_VALID && (cnt == LAST);

endmodule

// File: tb/tb_mdc_transpose_unit.sv
// Directed bench for mdc_transpose_unit (LANES=8, DW=64): transpose, stalls,
// bypass blocks, mid-block reset and, with MTU_FLUSH_EN, the drain tail.
module tb_mdc_transpose_unit;

  localparam int L   = 8;
  localparam int W   = 64;
  localparam int LAT = L - 1;

  logic           clk = 1'b0;
  logic           rstn;
  logic           in_valid;
  logic           bypass;
  logic [L*W-1:0] d;
  logic           out_valid;
  logic           blk_start;
  logic [L*W-1:0] q;
`ifdef MTU_FLUSH_EN
  logic           flush;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mdc_transpose_unit #(
    .LANES(L),
    .DW   (W)
  ) dut (
    .CLK      (clk),
    .RSTn     (rstn),
    .IN_VALID (in_valid),
    .BYPASS   (bypass),
    .D        (d),
`ifdef MTU_FLUSH_EN
    .FLUSH    (flush),
`endif
    .OUT_VALID(out_valid),
    .BLK_START(blk_start),
    .Q        (q)
  );

  function automatic logic [W-1:0] sv(input int blk, input int row, input int lane);
    return W'(100 * blk + 10 * row + lane);
  endfunction

  function automatic logic [L*W-1:0] in_row(input int blk, input int row);
    logic [L*W-1:0] v;
    for (int i = 0; i < L; i++) v[i*W +: W] = sv(blk, row, i);
    return v;
  endfunction

  // Output row r of a transposed block: lane j carries input row j, lane r.
  function automatic logic [L*W-1:0] xp_row(input int blk, input int r);
    logic [L*W-1:0] v;
    for (int j = 0; j < L; j++) v[j*W +: W] = sv(blk, j, r);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rstn     = 1'b0;
    in_valid = 1'b0;
    bypass   = 1'b0;
    d        = '0;
`ifdef MTU_FLUSH_EN
    flush    = 1'b0;
`endif
    step();
    step();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn     = 1'b0;
    in_valid = 1'b1;
    bypass   = 1'b0;
    d        = in_row(9, 9);
    @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    tests++; if (blk_start !== 1'b0) begin fails++; $display("FAIL reset_blk_start: got %b want 0", blk_start); end
    tests++; if (q !== '0) begin fails++; $display("FAIL reset_q: got %h want 0", q); end
    bypass = 1'b1;
    #1;
    tests++; if (q !== '0) begin fails++; $display("FAIL reset_q_bypass: got %h want 0", q); end
  endtask

  task automatic test_transpose();
    logic           exp_v, exp_bs;
    logic [L*W-1:0] exp_q;
    int             m;
    apply_reset();
    for (int k = 0; k < 3 * L + LAT; k++) begin
      in_valid = 1'b1;
      d        = in_row(k / L, k % L);
      @(negedge clk);
      m      = k - LAT;
      exp_v  = (k >= LAT);
      exp_bs = exp_v && (m % L == 0);
      tests++; if (out_valid !== exp_v) begin fails++; $display("FAIL xpose_valid beat %0d: got %b want %b", k, out_valid, exp_v); end
      tests++; if (blk_start !== exp_bs) begin fails++; $display("FAIL xpose_blk_start beat %0d: got %b want %b", k, blk_start, exp_bs); end
      if (exp_v) begin
        exp_q = xp_row(m / L, m % L);
        tests++; if (q !== exp_q) begin fails++; $display("FAIL xpose_q beat %0d: got %h want %h", k, q, exp_q); end
      end
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_stall();
    logic           exp_v, exp_bs;
    logic [L*W-1:0] exp_q;
    int             m, nst;
    apply_reset();
    for (int k = 0; k < 3 * L + LAT; k++) begin
      nst = (k % L == 2) ? 2 : ((k % L == 5) ? 1 : 0);
      m   = k - LAT;
      for (int st = 0; st < nst; st++) begin
        in_valid = 1'b0;
        d        = in_row(k / L, k % L);
        @(negedge clk);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stall_valid beat %0d: got %b want 0", k, out_valid); end
        tests++; if (blk_start !== 1'b0) begin fails++; $display("FAIL stall_blk_start beat %0d: got %b want 0", k, blk_start); end
        if (k >= LAT) begin
          exp_q = xp_row(m / L, m % L);
          tests++; if (q !== exp_q) begin fails++; $display("FAIL stall_hold beat %0d: got %h want %h", k, q, exp_q); end
        end
        step();
      end
      in_valid = 1'b1;
      d        = in_row(k / L, k % L);
      @(negedge clk);
      exp_v  = (k >= LAT);
      exp_bs = exp_v && (m % L == 0);
      tests++; if (out_valid !== exp_v) begin fails++; $display("FAIL stall_out_valid beat %0d: got %b want %b", k, out_valid, exp_v); end
      tests++; if (blk_start !== exp_bs) begin fails++; $display("FAIL stall_out_blk_start beat %0d: got %b want %b", k, blk_start, exp_bs); end
      if (exp_v) begin
        exp_q = xp_row(m / L, m % L);
        tests++; if (q !== exp_q) begin fails++; $display("FAIL stall_q beat %0d: got %h want %h", k, q, exp_q); end
      end
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_bypass();
    logic           exp_v, exp_bs;
    logic [L*W-1:0] exp_q;
    int             m;
    apply_reset();
    for (int k = 0; k < 3 * L + LAT; k++) begin
      in_valid = 1'b1;
      // A mid-block BYPASS pulse in block 0 must be ignored.
      bypass   = (k / L == 1) || (k == 3);
      d        = in_row(k / L, k % L);
      @(negedge clk);
      m      = k - LAT;
      exp_v  = (k >= LAT);
      exp_bs = exp_v && (m % L == 0);
      tests++; if (out_valid !== exp_v) begin fails++; $display("FAIL byp_valid beat %0d: got %b want %b", k, out_valid, exp_v); end
      tests++; if (blk_start !== exp_bs) begin fails++; $display("FAIL byp_blk_start beat %0d: got %b want %b", k, blk_start, exp_bs); end
      if (exp_v) begin
        exp_q = (m / L == 1) ? in_row(1, m % L) : xp_row(m / L, m % L);
        tests++; if (q !== exp_q) begin fails++; $display("FAIL byp_q beat %0d: got %h want %h", k, q, exp_q); end
      end
      step();
    end
    in_valid = 1'b0;
    bypass   = 1'b0;
  endtask

  task automatic test_mid_reset();
    logic           exp_v, exp_bs;
    logic [L*W-1:0] exp_q;
    int             m;
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      d        = in_row(7, k);
      @(negedge clk);
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_pre_valid beat %0d: got %b want 0", k, out_valid); end
      step();
    end
    rstn     = 1'b0;
    in_valid = 1'b1;
    d        = in_row(7, 4);
    @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
    tests++; if (blk_start !== 1'b0) begin fails++; $display("FAIL midrst_blk_start: got %b want 0", blk_start); end
    tests++; if (q !== '0) begin fails++; $display("FAIL midrst_q: got %h want 0", q); end
    step();
    rstn = 1'b1;
    for (int k = 0; k < L + LAT; k++) begin
      in_valid = 1'b1;
      d        = in_row(4 + k / L, k % L);
      @(negedge clk);
      m      = k - LAT;
      exp_v  = (k >= LAT);
      exp_bs = exp_v && (m % L == 0);
      tests++; if (out_valid !== exp_v) begin fails++; $display("FAIL midrst_out_valid beat %0d: got %b want %b", k, out_valid, exp_v); end
      tests++; if (blk_start !== exp_bs) begin fails++; $display("FAIL midrst_out_blk_start beat %0d: got %b want %b", k, blk_start, exp_bs); end
      if (exp_v) begin
        exp_q = xp_row(4, m);
        tests++; if (q !== exp_q) begin fails++; $display("FAIL midrst_q beat %0d: got %h want %h", k, q, exp_q); end
      end
      step();
    end
    in_valid = 1'b0;
  endtask

`ifdef MTU_FLUSH_EN
  task automatic test_flush();
    logic [L*W-1:0] exp_q;
    apply_reset();
    for (int k = 0; k < L; k++) begin
      in_valid = 1'b1;
      d        = in_row(2, k);
      @(negedge clk);
      tests++; if (out_valid !== (k == LAT)) begin fails++; $display("FAIL flush_fill_valid beat %0d: got %b want %b", k, out_valid, (k == LAT)); end
      if (k == LAT) begin
        exp_q = xp_row(2, 0);
        tests++; if (q !== exp_q) begin fails++; $display("FAIL flush_row0_q: got %h want %h", q, exp_q); end
        tests++; if (blk_start !== 1'b1) begin fails++; $display("FAIL flush_row0_blk_start: got %b want 1", blk_start); end
      end
      step();
    end
    in_valid = 1'b0;
    d        = in_row(8, 8);
    flush    = 1'b1;
    @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_pulse_valid: got %b want 0", out_valid); end
    step();
    flush = 1'b0;
    for (int r = 1; r < L; r++) begin
      @(negedge clk);
      exp_q = xp_row(2, r);
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL drain_valid row %0d: got %b want 1", r, out_valid); end
      tests++; if (blk_start !== 1'b0) begin fails++; $display("FAIL drain_blk_start row %0d: got %b want 0", r, blk_start); end
      tests++; if (q !== exp_q) begin fails++; $display("FAIL drain_q row %0d: got %h want %h", r, q, exp_q); end
      step();
    end
    @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL drain_end_valid: got %b want 0", out_valid); end
    step();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn     = 1'b0;
    in_valid = 1'b0;
    bypass   = 1'b0;
    d        = '0;
`ifdef MTU_FLUSH_EN
    flush    = 1'b0;
`endif
    test_reset();
    test_transpose();
    test_stall();
    test_bypass();
    test_mid_reset();
`ifdef MTU_FLUSH_EN
    test_flush();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mdc_transpose_unit.md
Name: mdc_transpose_unit

Overview:
- Parametrised multi-path delay-commutator (MDC) transpose unit.
- Successor to the fixed 8x8 external-select MTU in the HRMF datapath; sits between the first rotator and the second radix butterfly.
- Generalised to LANES lanes of DW-bit complex samples, using log2(LANES) commutator stages.
- Adds internally generated commutator selects, valid-qualified stalling, per-block bypass mode and a block-start marker.

Parameters:
- LANES, 8, lane count; power of two, 2..64; stage count S = log2(LANES).
- DW, 64, complex sample width; real in [DW-1:DW/2], imag in [DW/2-1:0]; opaque to the block.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RSTn  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  input row valid; one row = LANES samples.
- BYPASS  in  1  mode request; sampled on the first row of each block.
- D  in  LANES*DW  input row; lane i at [i*DW +: DW].
- FLUSH  in  1  drain request; port present only with MTU_FLUSH_EN.
- OUT_VALID  out  1  output row valid.
- BLK_START  out  1  high with OUT_VALID on row 0 of an output block.
- Q  out  LANES*DW  output row; lane j at [j*DW +: DW].

Behaviour:
- Beat: a cycle with enable EN = IN_VALID, or a drain beat (see Optional Feature). When EN=0, every register holds, and OUT_VALID=0 and BLK_START=0.
- Row counter cnt, log2(LANES) bits: increments by 1 mod LANES on every beat. Block boundary is cnt==0. Reset value 0.
- Stage s, for s = 0..S-1:
  - Delay Ds = LANES >> (s+1).
  - Pairs lanes (i, i+Ds) where bit (S-1-s) of i is 0.
  - Each pair has two Ds-deep enabled delay lines arranged as the standard MDC: upper path enters the second delay line, lower path passes through the first.
  - Swap select sel_s = cnt[S-1-s], forced to 0 when the stage's latched mode is bypass.
- Stage order: stage 0 is nearest the input; stage outputs feed the next stage directly. Total latency is LANES-1 beats, independent of mode.
- Transpose contract, non-bypass: for the input block starting at beat B, output lane j at beat B + r + LANES-1 equals input lane r at beat B + j, for r, j in 0..LANES-1.
- Bypass contract: output lane j at beat n+LANES-1 equals input lane j at beat n.
- Mode latching:
  - BYPASS is captured when a beat has cnt==0.
  - The captured bit travels through an LANES-1 deep enabled mode delay line.
  - Stage s uses the bit tapped at delay LANES-2*Ds, so each stage switches mode exactly on its own block window.
  - Mixed-mode consecutive blocks are legal; the overlap region yields the defined per-stage result; the golden model mirrors this.
- OUT_VALID:
  - Fill counter saturates at LANES-1 and counts beats since reset.
  - OUT_VALID = EN && fill==LANES-1.
  - The first LANES-1 beats after reset produce OUT_VALID=0.
- BLK_START = OUT_VALID && cnt==LANES-1. The output row-0 beat coincides with cnt = LANES-1 at the input side.
- Reset, including mid-block: cnt, fill, all delay lines and mode bits clear to 0; Q=0, OUT_VALID=0, BLK_START=0. A partial block is discarded; the next input row is row 0.
- Datapath: no arithmetic, pure reordering; bit-exact.

Optional Feature:
- MTU_FLUSH_EN defined: FLUSH port exists.
  - A FLUSH sample of 1 on any cycle loads the drain counter with LANES-1.
  - While drain>0 and IN_VALID=0, the cycle is a drain beat: EN=1, D is treated as all zero, and drain decrements.
  - A real beat while drain>0 also decrements drain; real data has priority.
  - FLUSH while drain>0 reloads the counter.
  - Drain beats produce OUT_VALID normally, so the tail of the last block emerges without further input.
- MTU_FLUSH_EN undefined: no FLUSH port, no drain logic; EN = IN_VALID.

Decomposition:
- Shared package holds:
  - The complex sample field layout (DW split and real/imag slice helpers).
  - A log2 function for LANES-derived widths.
- Natural sub-module: mdc_stage. It is parametrised by Ds and DW, and has CLK, RSTn, EN, SEL, two data inputs and two data outputs.
- The top instantiates LANES/2 mdc_stage per stage, plus the cnt, fill, mode and drain control.

Test Plan:
- LANES=8, DW=64; sample value = 100*blk + 10*row + lane; 3 back-to-back blocks -> first OUT_VALID at beat 7. Output row r, lane j = 100*blk + 10*j + r. BLK_START on beats 7, 15, 23.
- Same stream with IN_VALID low for 3 random cycles inside each block -> identical output sequence on OUT_VALID beats only; Q stable during stalls.
- BYPASS=1 for block 1 only, 0 for blocks 0 and 2 -> block 0 transposed and block 2 transposed; block 1 rows equal the input rows delayed 7 beats, with the per-stage transitions matching the golden model.
- Assert RSTn=0 after row 3 of a block, release, send a fresh block -> OUT_VALID low for 7 beats, then a correct transpose. All outputs are 0 during reset.
- MTU_FLUSH_EN: one block, then FLUSH pulse with IN_VALID=0 -> 7 drain beats emit rows 1..7 of the transpose; the 8th idle cycle gives OUT_VALID=0.
- LANES=4, DW=32 and LANES=16 builds -> transpose contract holds with latency 3 and 15 respectively.
